// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if: request (req_*), data-memory (mem_*) and response (resp_*) bundle; slave = queue, master = environment
interface mem_req_queue_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [63:0]      req_addr;
  logic [63:0]      req_wdata;
  logic [3:0]       req_size;
  logic             req_signed;
  logic [TAG_W-1:0] req_tag;
  logic [63:0]      mem_address;
  logic             mem_write_enable;
  logic             mem_read_enable;
  logic [63:0]      mem_write_data;
  logic [3:0]       mem_xfer_size;
  logic [63:0]      mem_read_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [TAG_W-1:0] resp_tag;
  logic [63:0]      resp_data;
  logic             resp_is_store;
  logic             resp_error;
  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_size, req_signed, req_tag, mem_read_data, resp_ready,
    output req_ready, mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size,
           resp_valid, resp_tag, resp_data, resp_is_store, resp_error
  );
  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_size, req_signed, req_tag, mem_read_data, resp_ready,
    input  req_ready, mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size,
           resp_valid, resp_tag, resp_data, resp_is_store, resp_error
  );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order load/store FIFO feeding data memory; ports clk, reset (async high), bus (req_* in, mem_* to memory, resp_* out)
module mem_req_queue #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int MEM_SIZE = 1024
) (
  input logic clk,
  input logic reset,
  mem_req_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [63:0] MEM_LIM = 64'(MEM_SIZE);
  logic             q_store  [DEPTH];
  logic [63:0]      q_addr   [DEPTH];
  logic [63:0]      q_wdata  [DEPTH];
  logic [3:0]       q_size   [DEPTH];
  logic             q_signed [DEPTH];
  logic [TAG_W-1:0] q_tag    [DEPTH];
  logic [AW:0]      count;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             h_store, h_signed, legal, push, issue, go;
  logic [63:0]      h_addr, h_wdata, rd, ld;
  logic [3:0]       h_size;
  logic             resp_valid;
  assign h_store  = q_store[rd_ptr];
  assign h_addr   = q_addr[rd_ptr];
  assign h_wdata  = q_wdata[rd_ptr];
  assign h_size   = q_size[rd_ptr];
  assign h_signed = q_signed[rd_ptr];
  // range test subtracts from the limit so a huge address cannot wrap past it
  assign legal = (h_size == 4'd1 || h_size == 4'd2 || h_size == 4'd4 || h_size == 4'd8)
              && (h_addr & {60'd0, h_size - 4'd1}) == 64'd0
              && h_addr < MEM_LIM && {60'd0, h_size} <= MEM_LIM - h_addr;
  assign push  = bus.req_valid && bus.req_ready;
  assign issue = !reset && count != '0 && (!resp_valid || bus.resp_ready);
  assign go    = issue && legal;
  assign bus.req_ready        = count < (AW+1)'(DEPTH);
  assign bus.mem_read_enable  = go && !h_store;
  assign bus.mem_write_enable = go && h_store;
  assign bus.mem_address      = go ? h_addr : 64'd0;
  assign bus.mem_write_data   = go && h_store ? h_wdata : 64'd0;
  assign bus.mem_xfer_size    = go ? h_size : 4'd8;
  assign bus.resp_valid       = resp_valid;
  assign rd = bus.mem_read_data;
  assign ld = h_size == 4'd1 ? {{56{h_signed & rd[7]}},  rd[7:0]}
            : h_size == 4'd2 ? {{48{h_signed & rd[15]}}, rd[15:0]}
            : h_size == 4'd4 ? {{32{h_signed & rd[31]}}, rd[31:0]}
            : rd;
  always_ff @(posedge clk) begin
    if (push) begin
      q_store[wr_ptr]  <= bus.req_is_store;
      q_addr[wr_ptr]   <= bus.req_addr;
      q_wdata[wr_ptr]  <= bus.req_wdata;
      q_size[wr_ptr]   <= bus.req_size;
      q_signed[wr_ptr] <= bus.req_signed;
      q_tag[wr_ptr]    <= bus.req_tag;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count + (AW+1)'(push) - (AW+1)'(issue);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(issue);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid        <= 1'b0;
      bus.resp_tag      <= '0;
      bus.resp_data     <= 64'd0;
      bus.resp_is_store <= 1'b0;
      bus.resp_error    <= 1'b0;
    end else if (issue) begin
      resp_valid        <= 1'b1;
      bus.resp_tag      <= q_tag[rd_ptr];
      bus.resp_data     <= go && !h_store ? ld : 64'd0;
      bus.resp_is_store <= h_store;
      bus.resp_error    <= !legal;
    end else if (bus.resp_ready) begin
      resp_valid <= 1'b0;
    end
  end
endmodule
